sine_rom_arbiter: RTL

- Shares one synchronous single-read-port sine ROM (256 x 8) between N_REQ phase-accumulator channels.
- Each channel issues a ROM address with a req/gnt handshake; the arbiter grants one channel per cycle in round-robin order.
- Read data returns one cycle after grant, tagged with a one-hot valid.
- Sits between the per-channel address counters (plus offset adders) and the ROM. This lets multi-tone generation use a single ROM instance.

---
 rtl/sine_arb_pkg.sv | 19 +
 rtl/sine_rom_arbiter_rr_pick.sv | 35 +++
 rtl/sine_rom_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/sine_arb_pkg.sv
// rtl/sine_arb_pkg.sv - shared constants, types and helpers for the sine ROM arbiter
package sine_arb_pkg;

  // Width of each per-channel grant statistics counter
  localparam int CNT_WIDTH = 16;

  // Largest supported channel count and default ROM address width
  localparam int MAX_REQ     = 8;
  localparam int ROM_A_WIDTH = 8;

  // Per-channel address table at the default ROM geometry
  typedef logic [ROM_A_WIDTH-1:0] addr_arr_t [MAX_REQ];

  // Round-robin pointer width; a two-channel arbiter still needs one bit
  function automatic int ptr_width(input int n_req);
    return (n_req <= 2) ? 1 : $clog2(n_req);
  endfunction

endpackage

// File: rtl/sine_rom_arbiter_rr_pick.sv
// rtl/sine_rom_arbiter_rr_pick.sv - combinational round-robin selector (module rr_pick)
module rr_pick
  import sine_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PW    = ptr_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PW-1:0]    idx
);

  // Scan from ptr upward with wrap; the first active request wins
  always_comb begin
    int  j;
    logic found;
    gnt   = '0;
    idx   = '0;
    j     = 0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) begin
        j = j - N_REQ;
      end
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/sine_rom_arbiter.sv
// rtl/sine_rom_arbiter.sv - round-robin sharing of one sine ROM read port; SINE_ARB_STATS_EN adds grant counters
module sine_rom_arbiter
  import sine_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int A_WIDTH = 8,
  parameter int D_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*A_WIDTH-1:0]   addr,
  output logic [N_REQ-1:0]           gnt,
  output logic                       rom_en,
  output logic [A_WIDTH-1:0]         rom_addr,
  input  logic [D_WIDTH-1:0]         rom_dout,
  output logic [N_REQ-1:0]           rvalid,
  output logic [D_WIDTH-1:0]         rdata
`ifdef SINE_ARB_STATS_EN
  ,
  input  logic                       stats_clr,
  output logic [N_REQ*CNT_WIDTH-1:0] gnt_cnt
`endif
);

  localparam int PW = ptr_width(N_REQ);

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0] rvalid_q, rvalid_d;
  logic [N_REQ-1:0] pick_gnt;
  logic [PW-1:0]    pick_idx;

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Grant is suppressed during reset; the granted channel's address drives the ROM
  always_comb begin
    gnt      = pick_gnt;
    rom_addr = '0;
    if (rst) begin
      gnt = '0;
    end
    rom_en = |gnt;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        rom_addr = addr[i*A_WIDTH +: A_WIDTH];
      end
    end
  end

  // Pointer moves just past the channel served; returns track grants one cycle later
  always_comb begin
    ptr_d    = ptr_q;
    rvalid_d = gnt;
    if (rom_en) begin
      if (pick_idx == PW'(N_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = pick_idx + 1'b1;
      end
    end
  end

  // Pointer and return-valid registers; reset drops any in-flight return
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q    <= '0;
      rvalid_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rom_dout;

`ifdef SINE_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_q [N_REQ];
  logic [CNT_WIDTH-1:0] cnt_d [N_REQ];

  // Saturating per-channel grant counters; clear overrides a same-cycle grant
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stats_clr) begin
        cnt_d[i] = '0;
      end else if (gnt[i] && (cnt_q[i] != {CNT_WIDTH{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Flatten counters onto the output bus, channel 0 in the low bits
  always_comb begin
    gnt_cnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gnt_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
    end
  end
`endif

endmodule
